// File: rtl/sudoku_pkg.sv
// Shared constants and types for the sudoku character loader.
// Enum encodings are fixed so the 2-bit class bus between decoder and loader is stable.
package sudoku_pkg;

  localparam int GRID_N = 9;
  localparam int CELL_W = 4;

  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;

  typedef enum logic {ST_LOAD = 1'b0, ST_DONE = 1'b1} state_e;

  typedef enum logic [1:0] {
    CLS_DIGIT = 2'd0,
    CLS_SKIP  = 2'd1,
    CLS_LF    = 2'd2,
    CLS_BAD   = 2'd3
  } char_cls_e;

endpackage

// File: rtl/sudoku_char_decode.sv
// Combinational byte classifier: ASCII byte -> {char class, cell value}.
// '0'-'9' map to their value; EMPTY_CHAR maps to an empty cell (value 0).
module sudoku_char_decode
  import sudoku_pkg::*;
#(
  parameter logic [7:0] EMPTY_CHAR = 8'h2E
) (
  input  logic [7:0] i_byte,
  output logic [1:0] o_cls,
  output logic [3:0] o_val
);

  always_comb begin
    o_cls = CLS_BAD;
    o_val = 4'd0;
    if (i_byte >= CH_0 && i_byte <= CH_9) begin
      // ASCII digits sit at 0x30-0x39, so the low nibble is the value
      o_cls = CLS_DIGIT;
      o_val = i_byte[3:0];
    end else if (i_byte == EMPTY_CHAR) begin
      o_cls = CLS_DIGIT;
      o_val = 4'd0;
    end else if (i_byte == CH_SP || i_byte == CH_TAB || i_byte == CH_CR) begin
      o_cls = CLS_SKIP;
    end else if (i_byte == CH_LF) begin
      o_cls = CLS_LF;
    end
  end

endmodule

// File: rtl/sudoku_char_loader.sv
// ASCII puzzle text -> row-major cell writes, 81 per frame, with a one-entry output register.
// Define SUDOKU_LINE_SYNC_EN to let LF resynchronise to the start of the next row.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
module sudoku_char_loader
  import sudoku_pkg::*;
#(
  parameter int         GRID_N     = 9,
  parameter logic [7:0] EMPTY_CHAR = 8'h2E
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       cell_valid,
  input  logic       cell_ready,
  output logic [3:0] cell_row,
  output logic [3:0] cell_col,
  output logic [3:0] cell_val,
  output logic       frame_done,
  output logic [6:0] cells_loaded,
  output logic       err_bad_char,
  output logic       dbg_state
);

  localparam logic [3:0] LAST_IDX  = 4'(GRID_N - 1);
  localparam logic [6:0] CELLS_MAX = 7'(GRID_N * GRID_N);

  state_e     r_state, w_next;
  logic [3:0] r_row, r_col;
  logic       r_cell_valid;
  logic [3:0] r_cell_row, r_cell_col, r_cell_val;
  logic [6:0] r_cells;
  logic       r_err;

  logic [1:0] w_cls;
  logic [3:0] w_val;
  logic       w_accept, w_load_acc, w_digit, w_last_cell, w_lf_jump, w_lf_done;

  sudoku_char_decode #(.EMPTY_CHAR(EMPTY_CHAR)) u_decode (
    .i_byte (in_data),
    .o_cls  (w_cls),
    .o_val  (w_val)
  );

  assign w_accept    = in_valid && in_ready;
  assign w_load_acc  = w_accept && (r_state == ST_LOAD);
  assign w_digit     = w_load_acc && (w_cls == CLS_DIGIT);
  assign w_last_cell = (r_row == LAST_IDX) && (r_col == LAST_IDX);

`ifdef SUDOKU_LINE_SYNC_EN
  assign w_lf_jump = w_load_acc && (w_cls == CLS_LF) && (r_col != 4'd0);
`else
  assign w_lf_jump = 1'b0;
`endif
  assign w_lf_done = w_lf_jump && (r_row == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst || clear) r_state <= ST_LOAD;
    else              r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOAD: if ((w_digit && w_last_cell) || w_lf_done) w_next = ST_DONE;
      ST_DONE: w_next = ST_DONE;
      default: w_next = ST_LOAD;
    endcase
  end

  always_comb begin
    frame_done = (r_state == ST_DONE);
    dbg_state  = r_state;
    if (rst || clear)            in_ready = 1'b0;
    else if (r_state == ST_LOAD) in_ready = !r_cell_valid || cell_ready;
    else                         in_ready = 1'b1;
  end

  // The position stays on (8,8) after the last cell; DONE alone marks completion.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_row        <= 4'd0;
      r_col        <= 4'd0;
      r_cell_valid <= 1'b0;
      r_cell_row   <= 4'd0;
      r_cell_col   <= 4'd0;
      r_cell_val   <= 4'd0;
      r_cells      <= 7'd0;
      r_err        <= 1'b0;
    end else begin
      if (w_digit) begin
        r_cell_valid <= 1'b1;
        r_cell_row   <= r_row;
        r_cell_col   <= r_col;
        r_cell_val   <= w_val;
        if (r_cells != CELLS_MAX) r_cells <= r_cells + 7'd1;
        if (!w_last_cell) begin
          if (r_col == LAST_IDX) begin
            r_col <= 4'd0;
            r_row <= r_row + 4'd1;
          end else begin
            r_col <= r_col + 4'd1;
          end
        end
      end else if (cell_ready) begin
        r_cell_valid <= 1'b0;
      end
      if (w_lf_jump && !w_lf_done) begin
        r_row <= r_row + 4'd1;
        r_col <= 4'd0;
      end
      if (w_load_acc && (w_cls == CLS_BAD)) r_err <= 1'b1;
    end
  end

  assign cell_valid   = r_cell_valid;
  assign cell_row     = r_cell_row;
  assign cell_col     = r_cell_col;
  assign cell_val     = r_cell_val;
  assign cells_loaded = r_cells;
  assign err_bad_char = r_err;

endmodule

// File: tb/tb_sudoku_char_loader.sv
// Directed bench for sudoku_char_loader: full frames, stalls, bad chars, clear, LF, post-DONE.
module tb_sudoku_char_loader;

  logic       clk = 1'b0;
  logic       rst, clear, in_valid, cell_ready;
  logic [7:0] in_data;
  logic       in_ready, cell_valid, frame_done, err_bad_char, dbg_state;
  logic [3:0] cell_row, cell_col, cell_val;
  logic [6:0] cells_loaded;

  int errors = 0;
  int checks = 0;

  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  logic [7:0]  row_pat[9];
  logic [3:0]  row_val[9];

  sudoku_char_loader dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .cell_valid   (cell_valid),
    .cell_ready   (cell_ready),
    .cell_row     (cell_row),
    .cell_col     (cell_col),
    .cell_val     (cell_val),
    .frame_done   (frame_done),
    .cells_loaded (cells_loaded),
    .err_bad_char (err_bad_char),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  // Downstream monitor: records each completed cell write.
  always begin
    @(negedge clk);
    #2;
    if (!rst && !clear && cell_valid && cell_ready)
      got_q.push_back({cell_row, cell_col, cell_val});
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout byte=%h in_ready=%b required=1", b, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_frame(input logic with_junk);
    for (int r = 0; r < 9; r++) begin
      for (int c = 0; c < 9; c++) begin
        send_byte(row_pat[c]);
        exp_q.push_back({4'(r), 4'(c), row_val[c]});
        if (with_junk && c == 3) send_byte(8'h78);
        if (with_junk && c == 6) send_byte(8'h20);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00; cell_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({cell_valid, frame_done, err_bad_char, dbg_state} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000", {cell_valid, frame_done, err_bad_char, dbg_state});
    end
    checks++;
    if (cells_loaded !== 7'd0) begin errors++; $display("FAIL reset_cells got=%0d exp=0", cells_loaded); end
    checks++;
    if ({cell_row, cell_col, cell_val} !== 12'h000) begin
      errors++; $display("FAIL reset_cell_bus got=%h exp=000", {cell_row, cell_col, cell_val});
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_full_frame();
    got_q.delete();
    exp_q.delete();
    send_frame(1'b0);
    @(negedge clk);
    #1;
    checks++;
    if ({frame_done, cell_valid, cell_row, cell_col, cell_val} !== {1'b1, 1'b1, 12'h880}) begin
      errors++;
      $display("FAIL last_cell got=%b/%b/%h exp=1/1/880", frame_done, cell_valid, {cell_row, cell_col, cell_val});
    end
    idle(3);
    checks++;
    if (got_q.size() !== 81) begin errors++; $display("FAIL frame_count got=%0d exp=81", got_q.size()); end
    if (got_q.size() >= 3) begin
      checks++;
      if (got_q[0] !== 12'h005) begin errors++; $display("FAIL first_write got=%h exp=005", got_q[0]); end
      checks++;
      if (got_q[2] !== 12'h020) begin errors++; $display("FAIL third_write got=%h exp=020", got_q[2]); end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL frame_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if ({frame_done, dbg_state, err_bad_char} !== 3'b110 || cells_loaded !== 7'd81) begin
      errors++;
      $display("FAIL frame_end got=done%b st%b err%b cells%0d exp=done1 st1 err0 cells81",
               frame_done, dbg_state, err_bad_char, cells_loaded);
    end
  endtask

  task automatic test_after_done();
    got_q.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL done_in_ready[%0d] got=%b exp=1", i, in_ready); end
      send_byte(8'h31 + 8'(i % 9));
    end
    idle(3);
    checks++;
    if (got_q.size() !== 0) begin errors++; $display("FAIL done_writes got=%0d exp=0", got_q.size()); end
    checks++;
    if (cells_loaded !== 7'd81 || frame_done !== 1'b1 || err_bad_char !== 1'b0) begin
      errors++;
      $display("FAIL done_hold got=cells%0d done%b err%b exp=cells81 done1 err0", cells_loaded, frame_done, err_bad_char);
    end
  endtask

  task automatic test_stall();
    do_clear();
    fork
      send_frame(1'b0);
      begin
        logic [11:0] snap;
        int n = 0;
        @(negedge clk);
        while (!(cell_valid && cell_row == 4'd4 && cell_col == 4'd4) && n < 600) begin
          @(negedge clk);
          n++;
        end
        checks++;
        if (!(cell_valid && cell_row == 4'd4 && cell_col == 4'd4)) begin
          errors++;
          $display("FAIL stall_find got=%b/%h exp=1/447", cell_valid, {cell_row, cell_col, cell_val});
        end else begin
          snap = {cell_row, cell_col, cell_val};
          cell_ready = 1'b0;
          checks++;
          if (snap !== 12'h447) begin errors++; $display("FAIL stall_cell got=%h exp=447", snap); end
          for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || cell_valid !== 1'b1 || {cell_row, cell_col, cell_val} !== snap) begin
              errors++;
              $display("FAIL stall_hold[%0d] got=rdy%b v%b %h exp=rdy0 v1 %h",
                       k, in_ready, cell_valid, {cell_row, cell_col, cell_val}, snap);
            end
            @(negedge clk);
          end
          cell_ready = 1'b1;
        end
      end
    join
    idle(3);
    checks++;
    if (got_q.size() !== 81) begin errors++; $display("FAIL stall_count got=%0d exp=81", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_bad_char();
    do_clear();
    #1;
    checks++;
    if (err_bad_char !== 1'b0 || dbg_state !== 1'b0) begin
      errors++; $display("FAIL clear_flags got=err%b st%b exp=err0 st0", err_bad_char, dbg_state);
    end
    send_frame(1'b1);
    idle(3);
    checks++;
    if (got_q.size() !== 81) begin errors++; $display("FAIL bad_count got=%0d exp=81", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bad_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (err_bad_char !== 1'b1 || cells_loaded !== 7'd81 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL bad_end got=err%b cells%0d done%b exp=err1 cells81 done1", err_bad_char, cells_loaded, frame_done);
    end
  endtask

  task automatic test_clear_mid();
    do_clear();
    for (int i = 0; i < 40; i++) send_byte(row_pat[i % 9]);
    idle(2);
    checks++;
    if (cells_loaded !== 7'd40 || got_q.size() !== 40) begin
      errors++; $display("FAIL mid_count got=cells%0d writes%0d exp=40/40", cells_loaded, got_q.size());
    end
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h37;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (cell_valid !== 1'b0 || cells_loaded !== 7'd0) begin
      errors++; $display("FAIL clear_state got=v%b cells%0d exp=v0 cells0", cell_valid, cells_loaded);
    end
    send_byte(8'h34);
    @(negedge clk);
    #1;
    checks++;
    if (cell_valid !== 1'b1 || {cell_row, cell_col, cell_val} !== 12'h004 || cells_loaded !== 7'd1) begin
      errors++;
      $display("FAIL clear_restart got=v%b %h cells%0d exp=v1 004 cells1",
               cell_valid, {cell_row, cell_col, cell_val}, cells_loaded);
    end
    idle(2);
  endtask

  task automatic test_lf();
    logic [11:0] exp_third;
    do_clear();
    send_byte(8'h31);
    send_byte(8'h32);
    send_byte(8'h0A);
    send_byte(8'h33);
    idle(3);
`ifdef SUDOKU_LINE_SYNC_EN
    exp_third = 12'h103;
`else
    exp_third = 12'h023;
`endif
    checks++;
    if (got_q.size() !== 3) begin
      errors++; $display("FAIL lf_count got=%0d exp=3", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 12'h001 || got_q[1] !== 12'h012) begin
        errors++; $display("FAIL lf_first got=%h,%h exp=001,012", got_q[0], got_q[1]);
      end
      checks++;
      if (got_q[2] !== exp_third) begin errors++; $display("FAIL lf_third got=%h exp=%h", got_q[2], exp_third); end
    end
    checks++;
    if (cells_loaded !== 7'd3 || err_bad_char !== 1'b0) begin
      errors++; $display("FAIL lf_cells got=cells%0d err%b exp=cells3 err0", cells_loaded, err_bad_char);
    end
  endtask

  initial begin
    row_pat = '{8'h35, 8'h33, 8'h2E, 8'h2E, 8'h37, 8'h2E, 8'h2E, 8'h2E, 8'h2E};
    row_val = '{4'd5, 4'd3, 4'd0, 4'd0, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0};
    test_reset();
    test_full_frame();
    test_after_done();
    test_stall();
    test_bad_char();
    test_clear_mid();
    test_lf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
